mm_pe_sequencer: RTL and testbench
==================================

# mm_pe_sequencer

Sequencer that runs one matrix product C = A·B on a single three-stage multiply-accumulate PE with no FIFO. It reads A and B from two synchronous-read memories and streams operand pairs into the PE with no bubbles. It drives the PE's valid_in, start and last strobes so that each dot product reaches the PE at the correct pipeline stage. It writes each finished C element to a result memory in row-major order.

## Interface
- DATA_WIDTH, 32, operand width of A/B elements
- ACC_WIDTH, 64, PE accumulator / C element width
- DIM_WIDTH, 8, width of each dimension field (max dimension 2^DIM_WIDTH-1)
- ADDR_WIDTH, 16, memory address width; M·K, K·N and M·N must each be ≤ 2^ADDR_WIDTH
- clk  in  1  clock
- clr_n  in  1  reset, asynchronous, active-low; the PE shares it
- go  in  1  start pulse; sampled only in IDLE
- cfg_m, cfg_n, cfg_k  in  DIM_WIDTH each  A is M×K, B is K×N; captured when go is accepted
- busy  out  1  high from the cycle after go is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the last C element has been written
- a_rd_en, b_rd_en  out  1  memory read strobes; read data is valid the next cycle
- a_addr, b_addr  out  ADDR_WIDTH  A read address is i·K+k; B read address is k·N+j
- a_rdata, b_rdata  in  DATA_WIDTH  memory read data
- pe_valid_in, pe_start, pe_last  out  1  PE control strobes
- pe_a, pe_b  out  DATA_WIDTH  PE operands; wired directly from a_rdata and b_rdata
- pe_c  in  ACC_WIDTH  PE accumulator output
- pe_output_valid  in  1  PE result strobe
- c_we  out  1  result write enable; equal to pe_output_valid
- c_addr  out  ADDR_WIDTH  result address i·N+j
- c_wdata  out  ACC_WIDTH  equal to pe_c

## Operation
- FSM states:
  - IDLE: go with all dimensions nonzero → RUN. go with any dimension zero → DONE, with no reads and no writes.
  - RUN: issues exactly one read pair per cycle for M·N·K cycles. The issue order is i outer, j middle, k inner. After the final issue → DRAIN.
  - DRAIN: waits for the final c_we → DONE.
  - DONE: done=1 and busy=1 for one cycle → IDLE.
- go outside IDLE is ignored. cfg_* is ignored except at acceptance.
- Address generation uses adders only, no multipliers:
  - a_addr = row_base + k. When k wraps and j < N−1, row_base holds. When j also wraps, row_base += K.
  - b_addr += N on each k step. When k wraps, b_addr becomes j+1, or 0 when j wraps.
- Per-issue tags first (k==0) and lastk (k==K−1) travel with each read:
  - pe_valid_in is a_rd_en delayed 1 cycle.
  - pe_last is lastk delayed 1 cycle.
  - pe_start is first delayed 3 cycles and gated by that slot's valid. The PE samples start when the product is in its stage 2, so start must appear 2 cycles after the matching valid_in.
- pe_start and pe_last are 0 in every cycle where their slot is not valid.
- K=1: every element has first and lastk both set.
- c_addr is an output counter starting at 0. It increments after each c_we and is reset to 0 on go acceptance.
- Reset (asynchronous, possible mid-operation):
  - FSM → IDLE; all counters, tag pipes and outputs → 0; busy=0, done=0.
  - In-flight work is discarded. Nothing is written after reset deasserts.

## Timing
- go is sampled at the edge ending cycle 0. The first read issues in cycle 1.
- A read issued in cycle t has: pe_valid_in in t+1, PE stage 1 in t+2, PE stage 2 in t+3 (pe_start here if first), and PE result in t+4.
- c_we for element e occurs 4 cycles after the issue of its k=K−1 read.
- Consecutive elements stream back-to-back. c_we pulses are spaced exactly K cycles apart.
- done occurs in cycle M·N·K+5. busy is high in cycles 1 through M·N·K+5. A new go is accepted at the earliest in cycle M·N·K+6.
- Zero dimension: done and busy are high in cycle 1 only.
- Reset values: every output is 0.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], M=N=K=2, go in cycle 0 → c_we in cycles 6, 8, 10, 12 with (c_addr, c_wdata) = (0,19), (1,22), (2,43), (3,50); done in cycle 13.
- M=1, N=1, K=3, A=[2,3,4], B=[5,6,7]:
  - a_addr 0,1,2 and b_addr 0,1,2 in cycles 1–3.
  - pe_start only in cycle 4; pe_last only in cycle 4; c_wdata=56 in cycle 7.
- K=1, M=2, N=3 → six c_we pulses in consecutive cycles 5–10, each with pe_start and pe_last set for its slot; c_addr 0–5.
- cfg_k=0 with go → busy and done high in cycle 1 only; no rd_en and no c_we.
- go pulsed in cycle 3 of a running 2×2×2 job → ignored; outputs are identical to the first test.
- clr_n asserted in cycle 5 of the 2×2×2 job and released, then a new go → no c_we between the reset and the new job; the new job produces correct results from c_addr 0.

Source files
------------

// File: rtl/mm_pe_sequencer_if.sv
// -----------------------------------------------------------------------------
// mm_pe_sequencer_if
// Groups every non-clock, non-reset signal of the matrix-product sequencer.
//   Command / status : go, cfg_m, cfg_n, cfg_k, busy, done
//   A / B memories   : a_rd_en, a_addr, a_rdata, b_rd_en, b_addr, b_rdata
//   PE               : pe_valid_in, pe_start, pe_last, pe_a, pe_b, pe_c,
//                      pe_output_valid
//   C memory         : c_we, c_addr, c_wdata
// Modports:
//   slave  - the sequencer's view (drives reads, PE strobes, C writes)
//   master - the surrounding system's view (host, memories, PE)
// -----------------------------------------------------------------------------
interface mm_pe_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int DIM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  go;
  logic [DIM_WIDTH-1:0]  cfg_m;
  logic [DIM_WIDTH-1:0]  cfg_n;
  logic [DIM_WIDTH-1:0]  cfg_k;
  logic                  busy;
  logic                  done;

  logic                  a_rd_en;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  b_rd_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  pe_valid_in;
  logic                  pe_start;
  logic                  pe_last;
  logic [DATA_WIDTH-1:0] pe_a;
  logic [DATA_WIDTH-1:0] pe_b;
  logic [ACC_WIDTH-1:0]  pe_c;
  logic                  pe_output_valid;

  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [ACC_WIDTH-1:0]  c_wdata;

  modport slave (
    input  go, cfg_m, cfg_n, cfg_k,
    output busy, done,
    output a_rd_en, a_addr, b_rd_en, b_addr,
    input  a_rdata, b_rdata,
    output pe_valid_in, pe_start, pe_last, pe_a, pe_b,
    input  pe_c, pe_output_valid,
    output c_we, c_addr, c_wdata
  );

  modport master (
    output go, cfg_m, cfg_n, cfg_k,
    input  busy, done,
    input  a_rd_en, a_addr, b_rd_en, b_addr,
    output a_rdata, b_rdata,
    input  pe_valid_in, pe_start, pe_last, pe_a, pe_b,
    output pe_c, pe_output_valid,
    input  c_we, c_addr, c_wdata
  );
endinterface

// File: rtl/mm_pe_sequencer.sv
// -----------------------------------------------------------------------------
// mm_pe_sequencer
// Runs one matrix product C = A*B (A is MxK, B is KxN) on a single three-stage
// multiply-accumulate PE. One A/B read pair is issued per cycle in i/j/k order
// (k innermost) with no bubbles; the read data goes straight to the PE and the
// PE results go straight to the C memory in row-major order.
// Ports:
//   clk    - clock
//   clr_n  - asynchronous active-low reset (shared with the PE)
//   bus    - mm_pe_sequencer_if.slave: go/cfg/busy/done, A/B read ports,
//            PE strobes and operands, C write port
// -----------------------------------------------------------------------------
module mm_pe_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int DIM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  mm_pe_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_next;

  logic [DIM_WIDTH-1:0]  r_cfg_m;
  logic [DIM_WIDTH-1:0]  r_cfg_n;
  logic [DIM_WIDTH-1:0]  r_cfg_k;
  logic [DIM_WIDTH-1:0]  r_i;
  logic [DIM_WIDTH-1:0]  r_j;
  logic [DIM_WIDTH-1:0]  r_k;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [ADDR_WIDTH-1:0] r_b_addr;
  logic [ADDR_WIDTH-1:0] r_c_addr;

  // Bit n of each pipe is the tag delayed n+1 cycles after its issue.
  logic [2:0]            r_valid_pipe;
  logic [2:0]            r_first_pipe;
  logic                  r_last_d1;
  // Dot products whose final read has issued but whose result has not yet
  // come back from the PE.
  logic [3:0]            r_pending;

  logic                  w_go_accept;
  logic                  w_issue;
  logic                  w_cfg_zero;
  logic                  w_k_wrap;
  logic                  w_j_wrap;
  logic                  w_i_wrap;
  logic                  w_final_issue;
  logic                  w_first;
  logic                  w_pend_inc;
  logic                  w_pend_dec;
  logic [DATA_WIDTH-1:0] w_a_data;
  logic [DATA_WIDTH-1:0] w_b_data;
  logic [ACC_WIDTH-1:0]  w_c_data;

  assign w_cfg_zero    = (bus.cfg_m == '0) || (bus.cfg_n == '0) || (bus.cfg_k == '0);
  assign w_k_wrap      = (r_k == r_cfg_k - DIM_ONE);
  assign w_j_wrap      = (r_j == r_cfg_n - DIM_ONE);
  assign w_i_wrap      = (r_i == r_cfg_m - DIM_ONE);
  assign w_final_issue = w_k_wrap && w_j_wrap && w_i_wrap;
  assign w_first       = (r_k == '0);
  assign w_pend_inc    = w_issue && w_k_wrap;
  assign w_pend_dec    = bus.pe_output_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_go_accept  = 1'b0;
    w_issue      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_go_accept  = 1'b1;
          w_state_next = w_cfg_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (w_final_issue) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Only the last outstanding result completes the job.
        if (w_pend_dec && (r_pending == 4'd1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

  // ---------------------------------------------------------------------------
  // Index counters and adder-only address generation
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cfg_m    <= '0;
      r_cfg_n    <= '0;
      r_cfg_k    <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_row_base <= '0;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
    end else if (w_go_accept) begin
      r_cfg_m    <= bus.cfg_m;
      r_cfg_n    <= bus.cfg_n;
      r_cfg_k    <= bus.cfg_k;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_row_base <= '0;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
    end else if (w_issue) begin
      if (!w_k_wrap) begin
        r_k      <= r_k + DIM_ONE;
        r_a_addr <= r_a_addr + ADDR_ONE;
        r_b_addr <= r_b_addr + ADDR_WIDTH'(r_cfg_n);
      end else begin
        r_k <= '0;
        if (!w_j_wrap) begin
          // Next column of B, same row of A.
          r_j      <= r_j + DIM_ONE;
          r_a_addr <= r_row_base;
          r_b_addr <= ADDR_WIDTH'(r_j) + ADDR_ONE;
        end else begin
          // Next row of A, back to column 0 of B.
          r_j        <= '0;
          r_i        <= r_i + DIM_ONE;
          r_row_base <= r_row_base + ADDR_WIDTH'(r_cfg_k);
          r_a_addr   <= r_row_base + ADDR_WIDTH'(r_cfg_k);
          r_b_addr   <= '0;
        end
      end
    end
  end

  assign bus.a_rd_en = w_issue;
  assign bus.b_rd_en = w_issue;
  assign bus.a_addr  = r_a_addr;
  assign bus.b_addr  = r_b_addr;

  // ---------------------------------------------------------------------------
  // Tag pipes. Tags are gated by the issue strobe when they enter, so a tag bit
  // can only be set where its slot is valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_valid_pipe <= '0;
      r_first_pipe <= '0;
      r_last_d1    <= 1'b0;
    end else begin
      r_valid_pipe <= {r_valid_pipe[1:0], w_issue};
      r_first_pipe <= {r_first_pipe[1:0], w_issue && w_first};
      r_last_d1    <= w_issue && w_k_wrap;
    end
  end

  // valid_in/last go with the operands; start lines up two cycles later, when
  // the first product of a dot product sits in the PE's accumulate stage.
  assign bus.pe_valid_in = r_valid_pipe[0];
  assign bus.pe_last     = r_last_d1;
  assign bus.pe_start    = r_first_pipe[2] && r_valid_pipe[2];

  assign w_a_data   = bus.a_rdata;
  assign w_b_data   = bus.b_rdata;
  assign bus.pe_a   = w_a_data;
  assign bus.pe_b   = w_b_data;

  // ---------------------------------------------------------------------------
  // Outstanding-result tracking and result write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pending <= '0;
    end else if (w_pend_inc && !w_pend_dec) begin
      r_pending <= r_pending + 4'd1;
    end else if (!w_pend_inc && w_pend_dec && (r_pending != '0)) begin
      r_pending <= r_pending - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_c_addr <= '0;
    end else if (w_go_accept) begin
      r_c_addr <= '0;
    end else if (bus.pe_output_valid) begin
      r_c_addr <= r_c_addr + ADDR_ONE;
    end
  end

  assign w_c_data    = bus.pe_c;
  assign bus.c_we    = bus.pe_output_valid;
  assign bus.c_addr  = r_c_addr;
  assign bus.c_wdata = w_c_data;

endmodule

// File: tb/tb_mm_pe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mm_pe_sequencer
// Table-driven bench for mm_pe_sequencer. Holds the A/B memories (synchronous
// read) and a three-stage MAC PE model, runs each job from a table of
// hand-computed results and checks every cycle's strobes, addresses and writes
// against the cycle timing of the design, plus hand-written sequences for an
// ignored mid-job go and an asynchronous reset mid-job.
// -----------------------------------------------------------------------------
module tb_mm_pe_sequencer;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int DMW = 8;
  localparam int ADW = 16;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  mm_pe_sequencer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DIM_WIDTH(DMW), .ADDR_WIDTH(ADW)) bus ();

  mm_pe_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DIM_WIDTH(DMW), .ADDR_WIDTH(ADW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Memories: read data valid the cycle after the strobe
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_a [0:63];
  logic [DW-1:0] mem_b [0:63];

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
    end else begin
      if (bus.a_rd_en) bus.a_rdata <= mem_a[bus.a_addr[5:0]];
      if (bus.b_rd_en) bus.b_rdata <= mem_b[bus.b_addr[5:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // PE model: operands with valid_in/last, stage 1 multiplies, stage 2
  // accumulates (restarting when pe_start is high), result registered out.
  // ---------------------------------------------------------------------------
  logic          s1_v, s1_last, s2_v, s2_last;
  logic [AW-1:0] s1_p, s2_p, acc;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_v <= 1'b0; s1_last <= 1'b0; s1_p <= '0;
      s2_v <= 1'b0; s2_last <= 1'b0; s2_p <= '0;
      acc <= '0;
      bus.pe_c <= '0;
      bus.pe_output_valid <= 1'b0;
    end else begin
      s1_v    <= bus.pe_valid_in;
      s1_last <= bus.pe_last;
      s1_p    <= AW'(bus.pe_a) * AW'(bus.pe_b);
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_p    <= s1_p;
      if (s2_v) begin
        acc      <= bus.pe_start ? s2_p : acc + s2_p;
        bus.pe_c <= bus.pe_start ? s2_p : acc + s2_p;
      end
      bus.pe_output_valid <= s2_v && s2_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct packed {
    logic [7:0]        m;
    logic [7:0]        n;
    logic [7:0]        k;
    logic [7:0]        done_cyc;
    logic [0:7][15:0]  a;
    logic [0:7][15:0]  b;
    logic [0:7][15:0]  c;
  } vec_t;

  vec_t vecs [0:6];

  task automatic set_vec(input int idx, input int m, input int n, input int k, input int d,
                         input logic [0:7][15:0] a, input logic [0:7][15:0] b,
                         input logic [0:7][15:0] c);
    vecs[idx].m        = 8'(m);
    vecs[idx].n        = 8'(n);
    vecs[idx].k        = 8'(k);
    vecs[idx].done_cyc = 8'(d);
    vecs[idx].a        = a;
    vecs[idx].b        = b;
    vecs[idx].c        = c;
  endtask

  // Runs table entry vi from go (cycle 0) to two cycles past done, checking
  // every cycle. If extra_go > 0 a stray go with different cfg is driven in
  // that cycle and must have no effect.
  task automatic run_job(input int vi, input int extra_go);
    vec_t v;
    int m, n, k, t_iss, d_cyc, nel;
    int r, ii, jj, kk, e;
    logic exp_rd, exp_valid, exp_start, exp_last, exp_we, exp_busy, exp_done;
    v = vecs[vi];
    m = int'(v.m); n = int'(v.n); k = int'(v.k);
    t_iss = m * n * k;
    nel = m * n;
    d_cyc = int'(v.done_cyc);
    for (int x = 0; x < 8; x++) begin
      mem_a[x] = DW'(v.a[x]);
      mem_b[x] = DW'(v.b[x]);
    end
    @(negedge clk);
    bus.cfg_m = v.m;
    bus.cfg_n = v.n;
    bus.cfg_k = v.k;
    bus.go = 1'b1;
    for (int c = 1; c <= d_cyc + 2; c++) begin
      @(posedge clk);
      #1;
      bus.go = 1'b0;
      if (c == extra_go) begin
        bus.go = 1'b1;
        bus.cfg_m = 8'd1;
        bus.cfg_n = 8'd1;
        bus.cfg_k = 8'd1;
      end
      @(negedge clk);
      exp_rd    = (c >= 1) && (c <= t_iss);
      exp_valid = (c >= 2) && (c - 1 <= t_iss);
      exp_start = (c >= 4) && (c - 3 <= t_iss) && (((c - 4) % k) == 0);
      exp_last  = (c >= 2) && (c - 1 <= t_iss) && (((c - 2) % k) == k - 1);
      exp_we    = (t_iss > 0) && (c >= k + 4) && (((c - 4) % k) == 0) && ((c - 4) / k - 1 < nel);
      exp_busy  = (c >= 1) && (c <= d_cyc);
      exp_done  = (c == d_cyc);
      chk($sformatf("job%0d cyc%0d ctl{rd_a,rd_b,vin,start,last,we,busy,done}", vi, c),
          64'({bus.a_rd_en, bus.b_rd_en, bus.pe_valid_in, bus.pe_start, bus.pe_last,
               bus.c_we, bus.busy, bus.done}),
          64'({exp_rd, exp_rd, exp_valid, exp_start, exp_last, exp_we, exp_busy, exp_done}));
      if (exp_rd) begin
        r  = c - 1;
        kk = r % k;
        jj = (r / k) % n;
        ii = r / (k * n);
        chk($sformatf("job%0d cyc%0d a_addr", vi, c), 64'(bus.a_addr), 64'(ii * k + kk));
        chk($sformatf("job%0d cyc%0d b_addr", vi, c), 64'(bus.b_addr), 64'(kk * n + jj));
      end
      if (exp_valid) begin
        r  = c - 2;
        kk = r % k;
        jj = (r / k) % n;
        ii = r / (k * n);
        chk($sformatf("job%0d cyc%0d pe_a", vi, c), 64'(bus.pe_a), 64'(v.a[ii * k + kk]));
        chk($sformatf("job%0d cyc%0d pe_b", vi, c), 64'(bus.pe_b), 64'(v.b[kk * n + jj]));
      end
      if (exp_we) begin
        e = (c - 4) / k - 1;
        $display("job%0d cycle %0d write c_addr=%0d c_wdata=%0d", vi, c, bus.c_addr, bus.c_wdata);
        chk($sformatf("job%0d cyc%0d c_addr", vi, c), 64'(bus.c_addr), 64'(e));
        chk($sformatf("job%0d cyc%0d c_wdata", vi, c), 64'(bus.c_wdata), 64'(v.c[e]));
      end
    end
    $display("job%0d M=%0d N=%0d K=%0d finished", vi, m, n, k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.go = 1'b0;
    bus.cfg_m = '0;
    bus.cfg_n = '0;
    bus.cfg_k = '0;
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end

    //      idx  M  N  K  done  A                                                     B                                                        C
    set_vec(0,   2, 2, 2, 13, {16'd1, 16'd2, 16'd3, 16'd4, {4{16'd0}}},              {16'd5, 16'd6, 16'd7, 16'd8, {4{16'd0}}},
                              {16'd19, 16'd22, 16'd43, 16'd50, {4{16'd0}}});
    set_vec(1,   1, 1, 3,  8, {16'd2, 16'd3, 16'd4, {5{16'd0}}},                     {16'd5, 16'd6, 16'd7, {5{16'd0}}},
                              {16'd56, {7{16'd0}}});
    set_vec(2,   2, 3, 1, 11, {16'd2, 16'd3, {6{16'd0}}},                            {16'd4, 16'd5, 16'd6, {5{16'd0}}},
                              {16'd8, 16'd10, 16'd12, 16'd12, 16'd15, 16'd18, {2{16'd0}}});
    set_vec(3,   2, 2, 0,  1, {8{16'd9}},                                            {8{16'd9}},
                              {8{16'd0}});
    set_vec(4,   2, 2, 3, 17, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, {2{16'd0}}}, {16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, {2{16'd0}}},
                              {16'd58, 16'd64, 16'd139, 16'd154, {4{16'd0}}});
    set_vec(5,   3, 1, 2, 11, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, {2{16'd0}}}, {16'd7, 16'd8, {6{16'd0}}},
                              {16'd23, 16'd53, 16'd83, {5{16'd0}}});
    set_vec(6,   0, 3, 2,  1, {8{16'd9}},                                            {8{16'd9}},
                              {8{16'd0}});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", 64'({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.pe_valid_in,
                          bus.pe_start, bus.pe_last, bus.c_we}), 64'(0));
    chk("reset addrs", 64'({bus.a_addr, bus.b_addr, bus.c_addr}), 64'(0));
    clr_n = 1'b1;

    // Table of jobs.
    for (int vi = 0; vi < 7; vi++) begin
      run_job(vi, 0);
    end

    // Stray go (with different cfg) in cycle 3 of a running 2x2x2 job.
    run_job(0, 3);

    // Asynchronous reset in cycle 5 of a 2x2x2 job, then a fresh job.
    for (int x = 0; x < 8; x++) begin
      mem_a[x] = DW'(vecs[0].a[x]);
      mem_b[x] = DW'(vecs[0].b[x]);
    end
    @(negedge clk);
    bus.cfg_m = 8'd2;
    bus.cfg_n = 8'd2;
    bus.cfg_k = 8'd2;
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre-reset busy/rd_en", 64'({bus.busy, bus.a_rd_en}), 64'(2'b11));
    clr_n = 1'b0;
    #1;
    chk("async reset ctl", 64'({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.pe_valid_in,
                                bus.pe_start, bus.pe_last, bus.c_we}), 64'(0));
    chk("async reset addrs", 64'({bus.a_addr, bus.b_addr, bus.c_addr}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset quiet cyc%0d {rd,we,busy,done}", c),
          64'({bus.a_rd_en, bus.c_we, bus.busy, bus.done}), 64'(0));
    end
    run_job(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
